// File: rtl/my_spi_master.sv
// SPI initiator for the 32-bit register link: {wr, addr[14:0]} then 16 data bits, MSB first.
// All SPI pins are registered; MISO is assumed already synchronised externally.
module my_spi_master #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        start,
  input  logic        wr,
  input  logic [14:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  // Hold spans the trailing low half-period after the last rise plus the CS hold time.
  localparam logic [15:0] HoldLast = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] GapLast  = (GAP_CYC > 1) ? 16'(GAP_CYC - 2) : 16'd0;

  state_e      r_state;
  logic [15:0] r_cnt;
  logic [4:0]  r_bit;
  logic [31:0] r_frame;
  logic [15:0] r_shadow;
  logic [15:0] r_rdata;
  logic        r_busy;
  logic        r_done;
  logic        r_sclk;
  logic        r_cs_n;
  logic        r_mosi;

  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_shadow <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_frame  <= {wr, addr, wr ? wdata : 16'h0000};
            r_mosi   <= wr;
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shadow <= '0;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          if (r_cnt == DivLast) begin
            r_sclk  <= 1'b1;
            r_cnt   <= '0;
            r_state <= StHigh;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StHigh: begin
          if (r_cnt == DivLast) begin
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            if (r_bit == 5'd31) begin
              r_state <= StHold;
            end else begin
              r_mosi  <= r_frame[5'd30 - r_bit];
              r_state <= StLow;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StLow: begin
          if (r_cnt == DivLast) begin
            // Sample MISO just before the rise of data bits 16..31.
            if (r_bit >= 5'd15) begin
              r_shadow <= {r_shadow[14:0], spi_miso};
            end
            r_sclk  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= r_bit + 5'd1;
            r_state <= StHigh;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_cs_n <= 1'b1;
            r_cnt  <= '0;
            if (GAP_CYC <= 1) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_rdata <= r_shadow;
              r_state <= StIdle;
            end else begin
              r_state <= StGap;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StGap: begin
          // The final gap cycle is spent in idle with done asserted.
          if (r_cnt == GapLast) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_rdata <= r_shadow;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign spi_sclk = r_sclk;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_my_spi_master.sv
// Directed bench for my_spi_master: two instances (default divider and CLK_DIV=6/GAP_CYC=1),
// each with a small SPI register-file slave model.
module tb_my_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [14:0] addr = '0;
  logic [15:0] wdata = '0;

  logic        busy8, done8, sclk8, cs8, mosi8;
  logic        busy6, done6, sclk6, cs6, mosi6;
  logic [15:0] rdata8, rdata6;
  logic        miso8 = 1'b0;
  logic        miso6 = 1'b0;

  always #5 clk = ~clk;

  my_spi_master #(.CLK_DIV(8), .GAP_CYC(16)) u_dut8 (
    .theClock(clk), .theReset(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy8), .done(done8), .rdata(rdata8), .spi_sclk(sclk8), .spi_cs_n(cs8),
    .spi_mosi(mosi8), .spi_miso(miso8)
  );

  my_spi_master #(.CLK_DIV(6), .GAP_CYC(1)) u_dut6 (
    .theClock(clk), .theReset(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy6), .done(done6), .rdata(rdata6), .spi_sclk(sclk6), .spi_cs_n(cs6),
    .spi_mosi(mosi6), .spi_miso(miso6)
  );

  // Slave models: capture MOSI on each rise, present read data after the address word.
  logic [15:0] sval8 = '0, sval6 = '0;
  logic [31:0] cap8 = '0, cap6 = '0;
  int          rise8 = 0, rise6 = 0;

  always @(posedge sclk8 or negedge cs8) begin
    if (sclk8) begin
      cap8 = {cap8[30:0], mosi8};
      if (rise8 >= 15 && rise8 <= 30) miso8 <= sval8[30 - rise8];
      rise8++;
    end else begin
      cap8 = '0;
      rise8 = 0;
      miso8 <= 1'b0;
    end
  end

  always @(posedge sclk6 or negedge cs6) begin
    if (sclk6) begin
      cap6 = {cap6[30:0], mosi6};
      if (rise6 >= 15 && rise6 <= 30) miso6 <= sval6[30 - rise6];
      rise6++;
    end else begin
      cap6 = '0;
      rise6 = 0;
      miso6 <= 1'b0;
    end
  end

  logic        sel = 1'b0;
  logic        o_busy, o_done, o_sclk, o_cs, o_mosi;
  logic [15:0] o_rdata;
  always_comb begin
    o_busy  = sel ? busy6 : busy8;
    o_done  = sel ? done6 : done8;
    o_sclk  = sel ? sclk6 : sclk8;
    o_cs    = sel ? cs6 : cs8;
    o_mosi  = sel ? mosi6 : mosi8;
    o_rdata = sel ? rdata6 : rdata8;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last run_frame (cycle numbers: cycle 0 = start accepted).
  int          first_rise, rises, cs_low, csh_cyc, cs_fall2, done_cnt, done_cyc, done2_cyc;
  logic [15:0] rd_at_done;
  logic        busy_at_done;
  logic [31:0] cap_at_csh;
  logic        rs_cs, rs_sclk, rs_busy, rs_done, rs_mosi;
  logic [15:0] rs_rdata;

  task automatic run_frame(input logic w, input logic [14:0] a, input logic [15:0] d,
                           input int ncyc, input int restart_at, input bit hold,
                           input int rst_at);
    logic prev_sclk, prev_cs;
    first_rise = 0; rises = 0; cs_low = 0; csh_cyc = 0; cs_fall2 = 0;
    done_cnt = 0; done_cyc = 0; done2_cyc = 0;
    rd_at_done = 'x; busy_at_done = 1'bx; cap_at_csh = 'x;
    @(negedge clk);
    wr = w; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    prev_sclk = 1'b0;
    prev_cs = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      if (restart_at != 0 && c == restart_at) start = 1'b1;
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        #1;
        rs_cs = o_cs; rs_sclk = o_sclk; rs_busy = o_busy; rs_done = o_done;
        rs_mosi = o_mosi; rs_rdata = o_rdata;
      end
      if (rst_at != 0 && c == rst_at + 1) rst = 1'b0;
      if (o_sclk && !prev_sclk) begin
        rises++;
        if (first_rise == 0) first_rise = c;
      end
      if (!o_cs) cs_low++;
      if (o_cs && !prev_cs && csh_cyc == 0) begin
        csh_cyc = c;
        cap_at_csh = sel ? cap6 : cap8;
      end
      if (!o_cs && prev_cs && csh_cyc != 0 && cs_fall2 == 0) begin
        cs_fall2 = c;
        if (hold) start = 1'b0;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          rd_at_done = o_rdata;
          busy_at_done = o_busy;
        end else if (done2_cyc == 0) begin
          done2_cyc = c;
        end
      end
      prev_sclk = o_sclk;
      prev_cs = o_cs;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_cs !== 1'b1) begin n_err++; $display("FAIL rst_cs: got %b want 1", o_cs); end
    n_cmp++; if (o_sclk !== 1'b0) begin n_err++; $display("FAIL rst_sclk: got %b want 0", o_sclk); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", o_done); end
    n_cmp++; if (o_mosi !== 1'b0) begin n_err++; $display("FAIL rst_mosi: got %b want 0", o_mosi); end
    n_cmp++;
    if (o_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", o_rdata); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_cs !== 1'b1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL rst_idle: got cs=%b busy=%b want cs=1 busy=0", o_cs, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    sval8 = 16'h01A5;
    run_frame(1'b0, 15'h001, 16'hFFFF, 560, 0, 1'b0, 0);
    n_cmp++;
    if (first_rise !== 9) begin n_err++; $display("FAIL rd_first_rise: got %0d want 9", first_rise); end
    n_cmp++;
    if (cap_at_csh !== 32'h0001_0000) begin
      n_err++; $display("FAIL rd_mosi_frame: got %h want 00010000", cap_at_csh);
    end
    n_cmp++;
    if (done_cyc !== 544) begin n_err++; $display("FAIL rd_done_cyc: got %0d want 544", done_cyc); end
    n_cmp++;
    if (rd_at_done !== 16'h01A5) begin n_err++; $display("FAIL rd_rdata: got %h want 01a5", rd_at_done); end
    n_cmp++;
    if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL rd_busy_done: got %b want 0", busy_at_done); end
    n_cmp++;
    if (o_rdata !== 16'h01A5) begin n_err++; $display("FAIL rd_rdata_held: got %h want 01a5", o_rdata); end
  endtask

  task automatic test_write();
    sval8 = 16'h5A5A;
    run_frame(1'b1, 15'h000, 16'h00FF, 560, 0, 1'b0, 0);
    n_cmp++;
    if (cap_at_csh !== 32'h8000_00FF) begin
      n_err++; $display("FAIL wr_mosi_frame: got %h want 800000ff", cap_at_csh);
    end
    n_cmp++; if (rises !== 32) begin n_err++; $display("FAIL wr_rises: got %0d want 32", rises); end
    n_cmp++; if (cs_low !== 528) begin n_err++; $display("FAIL wr_cs_low: got %0d want 528", cs_low); end
    n_cmp++; if (csh_cyc !== 529) begin n_err++; $display("FAIL wr_cs_high: got %0d want 529", csh_cyc); end
    n_cmp++;
    if (rd_at_done !== 16'h5A5A) begin n_err++; $display("FAIL wr_rdata_old: got %h want 5a5a", rd_at_done); end
  endtask

  task automatic test_reset_midframe();
    sval8 = 16'h1234;
    run_frame(1'b0, 15'h005, 16'h0000, 600, 0, 1'b0, 200);
    n_cmp++;
    if (rs_cs !== 1'b1 || rs_sclk !== 1'b0 || rs_busy !== 1'b0 || rs_mosi !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_pins: got cs=%b sclk=%b busy=%b mosi=%b want 1 0 0 0",
               rs_cs, rs_sclk, rs_busy, rs_mosi);
    end
    n_cmp++;
    if (rs_rdata !== 16'h0000) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 0000", rs_rdata); end
    n_cmp++;
    if (rs_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %b want 0", rs_done); end
    n_cmp++;
    if (done_cnt !== 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d want 0", done_cnt); end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_ignore_start();
    sval8 = 16'h0F0F;
    run_frame(1'b0, 15'h002, 16'h0000, 700, 100, 1'b0, 0);
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc !== 544) begin n_err++; $display("FAIL ign_done_cyc: got %0d want 544", done_cyc); end
    n_cmp++;
    if (cs_fall2 !== 0) begin n_err++; $display("FAIL ign_second_frame: got %0d want 0", cs_fall2); end
  endtask

  task automatic test_back_to_back();
    sval8 = 16'hC3C3;
    run_frame(1'b0, 15'h003, 16'h0000, 1100, 0, 1'b1, 0);
    n_cmp++;
    if (cs_fall2 !== 545) begin n_err++; $display("FAIL b2b_start2: got %0d want 545", cs_fall2); end
    n_cmp++;
    if (cs_fall2 - csh_cyc !== 16) begin
      n_err++; $display("FAIL b2b_gap: got %0d want 16", cs_fall2 - csh_cyc);
    end
    n_cmp++; if (done_cnt !== 2) begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
    n_cmp++;
    if (done2_cyc !== 1088) begin n_err++; $display("FAIL b2b_done2: got %0d want 1088", done2_cyc); end
    n_cmp++;
    if (o_rdata !== 16'hC3C3) begin n_err++; $display("FAIL b2b_rdata: got %h want c3c3", o_rdata); end
  endtask

  task automatic test_div6();
    sel = 1'b1;
    sval6 = 16'hBEEF;
    run_frame(1'b0, 15'h043, 16'h0000, 450, 0, 1'b0, 0);
    n_cmp++;
    if (first_rise !== 7) begin n_err++; $display("FAIL d6_first_rise: got %0d want 7", first_rise); end
    n_cmp++;
    if (cap_at_csh !== 32'h0043_0000) begin
      n_err++; $display("FAIL d6_mosi_frame: got %h want 00430000", cap_at_csh);
    end
    n_cmp++;
    if (csh_cyc !== 397) begin n_err++; $display("FAIL d6_cs_high: got %0d want 397", csh_cyc); end
    n_cmp++;
    if (done_cyc !== 397) begin n_err++; $display("FAIL d6_done_cyc: got %0d want 397", done_cyc); end
    n_cmp++;
    if (rd_at_done !== 16'hBEEF) begin n_err++; $display("FAIL d6_rdata: got %h want beef", rd_at_done); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL d6_done_cnt: got %0d want 1", done_cnt); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_reset_midframe();
    test_ignore_start();
    test_back_to_back();
    test_div6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
